lsu_mem_arbiter: RTL



---
 rtl/lsu_mem_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/lsu_mem_arbiter.sv
// Shares the single data-memory port between load issue (LDQ) and store commit (SDQ).
// One transaction in flight; loads win unless the head store is urgent or has been starved.
module lsu_mem_arbiter #(
    parameter int  LDQ_ENTRIES  = 8,
    parameter int  STARVE_LIMIT = 4,
    localparam int IW           = $clog2(LDQ_ENTRIES)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ld_vld_i,
    input  logic [31:0]   ld_addr_i,
    input  logic [IW-1:0] ld_idx_i,
    output logic          ld_issue_en_o,
    input  logic          st_vld_i,
    input  logic          st_urgent_i,
    input  logic [31:0]   st_addr_i,
    input  logic [31:0]   st_data_i,
    input  logic [3:0]    st_be_i,
    output logic          st_grant_o,
    output logic          mem_req_vld_o,
    output logic          mem_req_we_o,
    output logic [31:0]   mem_req_addr_o,
    output logic [31:0]   mem_req_wdata_o,
    output logic [3:0]    mem_req_be_o,
    input  logic          mem_req_rdy_i,
    input  logic          mem_resp_vld_i,
    input  logic [31:0]   mem_resp_rdata_i,
    output logic          ld_wb_vld_o,
    output logic [IW-1:0] ld_wb_idx_o,
    output logic [31:0]   ld_wb_data_o,
    output logic          busy_o
);

    // state | meaning
    // IDLE  | arbitrating; a load or a store may be accepted this cycle
    // REQ   | latched request presented to memory, held until mem_req_rdy_i
    // WAIT  | request taken by memory; waiting for read data or write ack
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam int                SCW        = $clog2(STARVE_LIMIT + 1);
    localparam logic [SCW-1:0]    STARVE_MAX = SCW'(STARVE_LIMIT);

    state_t           state_q, state_d;
    logic [SCW-1:0]   starve_cnt_q, starve_cnt_d;
    logic             req_we_q, req_we_d;
    logic [31:0]      req_addr_q, req_addr_d;
    logic [31:0]      req_wdata_q, req_wdata_d;
    logic [3:0]       req_be_q, req_be_d;
    logic [IW-1:0]    req_idx_q, req_idx_d;
    logic             wb_vld_q, wb_vld_d;
    logic [IW-1:0]    wb_idx_q, wb_idx_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             st_prio;
    logic             ld_accept;

    always_comb begin
        st_prio       = st_vld_i & (st_urgent_i | (starve_cnt_q == STARVE_MAX));
        // The enable must not look at ld_vld_i: the LDQ derives its valid from it.
        ld_issue_en_o = (state_q == IDLE) & ~st_prio;
        ld_accept     = ld_issue_en_o & ld_vld_i;
        st_grant_o    = (state_q == IDLE) & st_vld_i & ~ld_accept;

        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        req_we_d     = req_we_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        req_be_d     = req_be_q;
        req_idx_d    = req_idx_q;
        wb_vld_d     = 1'b0;
        wb_idx_d     = wb_idx_q;
        wb_data_d    = wb_data_q;

        case (state_q)
            IDLE: begin
                if (ld_accept) begin
                    state_d    = REQ;
                    req_we_d   = 1'b0;
                    req_addr_d = ld_addr_i;
                    req_idx_d  = ld_idx_i;
                    req_be_d   = 4'hF;
                    if (st_vld_i && starve_cnt_q != STARVE_MAX)
                        starve_cnt_d = starve_cnt_q + SCW'(1);
                end else if (st_vld_i) begin
                    state_d      = REQ;
                    req_we_d     = 1'b1;
                    req_addr_d   = st_addr_i;
                    req_wdata_d  = st_data_i;
                    req_be_d     = st_be_i;
                    starve_cnt_d = '0;
                end
            end
            REQ: begin
                if (mem_req_rdy_i)
                    state_d = WAIT;
            end
            WAIT: begin
                if (mem_resp_vld_i) begin
                    state_d = IDLE;
                    if (!req_we_q) begin
                        wb_vld_d  = 1'b1;
                        wb_idx_d  = req_idx_q;
                        wb_data_d = mem_resp_rdata_i;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!st_vld_i)
            starve_cnt_d = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            req_we_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_be_q     <= '0;
            req_idx_q    <= '0;
            wb_vld_q     <= 1'b0;
            wb_idx_q     <= '0;
            wb_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            req_we_q     <= req_we_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            req_be_q     <= req_be_d;
            req_idx_q    <= req_idx_d;
            wb_vld_q     <= wb_vld_d;
            wb_idx_q     <= wb_idx_d;
            wb_data_q    <= wb_data_d;
        end
    end

    assign mem_req_vld_o   = (state_q == REQ);
    assign mem_req_we_o    = req_we_q;
    assign mem_req_addr_o  = req_addr_q;
    assign mem_req_wdata_o = req_wdata_q;
    assign mem_req_be_o    = req_be_q;
    assign ld_wb_vld_o     = wb_vld_q;
    assign ld_wb_idx_o     = wb_idx_q;
    assign ld_wb_data_o    = wb_data_q;
    assign busy_o          = (state_q != IDLE);

endmodule
